// File: rtl/fifo_rd_check.sv
// Read-side burst engine and incrementing-sequence checker for the loopback FIFO.
// Define FIFO_RD_TIMEOUT_EN to build the idle watchdog that drives timeout.
module fifo_rd_check #(
    parameter int DATA_W  = 8,
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 1024
) (
    input  logic              clk_50M,
    input  logic              rst_n,
    input  logic              almost_full,
    input  logic              almost_empty,
    input  logic              empty,
    input  logic [DATA_W-1:0] rd_data,
    output logic              rd_en,
    output logic              err_flag,
    output logic [CNT_W-1:0]  err_cnt,
    output logic [CNT_W-1:0]  word_cnt,
    output logic [CNT_W-1:0]  burst_cnt,
    output logic              timeout
);

    typedef enum logic {
        IDLE,
        READ
    } state_t;

    state_t            state;
    logic              rd_vld;
    logic              locked;
    logic [DATA_W-1:0] exp_data;
    logic              burst_done;

    assign rd_en      = (state == READ) && !empty;
    // Last word leaving (almost_empty while reading) or the FIFO ran dry.
    assign burst_done = (state == READ) && ((rd_en && almost_empty) || empty);

    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            burst_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (almost_full)
                        state <= READ;
                end
                READ: begin
                    if (burst_done) begin
                        state <= IDLE;
                        if (burst_cnt != '1)
                            burst_cnt <= burst_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            rd_vld   <= 1'b0;
            locked   <= 1'b0;
            exp_data <= '0;
            err_flag <= 1'b0;
            err_cnt  <= '0;
            word_cnt <= '0;
        end else begin
            rd_vld <= rd_en;
            if (rd_vld) begin
                word_cnt <= word_cnt + 1'b1;
                exp_data <= rd_data + 1'b1;
                if (!locked) begin
                    locked <= 1'b1;
                end else if (rd_data != exp_data) begin
                    err_flag <= 1'b1;
                    if (err_cnt != '1)
                        err_cnt <= err_cnt + 1'b1;
                end
            end
        end
    end

`ifdef FIFO_RD_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT + 1);

    logic [TO_W-1:0] to_cnt;

    // Counts only idle cycles that do not start a burst; flag rises as the count reaches TIMEOUT.
    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt  <= '0;
            timeout <= 1'b0;
        end else if (state == IDLE && !almost_full) begin
            if (to_cnt != TO_W'(TIMEOUT)) begin
                to_cnt <= to_cnt + 1'b1;
                if (to_cnt == TO_W'(TIMEOUT - 1))
                    timeout <= 1'b1;
            end
        end else begin
            to_cnt <= '0;
        end
    end
`else
    assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_rd_check.sv
// Bench for fifo_rd_check: FIFO model, burst vector table and scoreboard of per-word checker results.
module tb_fifo_rd_check;

    logic        clk_50M = 1'b0;
    logic        rst_n = 1'b0;
    logic        almost_full = 1'b0;
    logic        almost_empty = 1'b0;
    logic        empty = 1'b1;
    logic [7:0]  rd_data = '0;
    logic        rd_en;
    logic        err_flag;
    logic [15:0] err_cnt;
    logic [15:0] word_cnt;
    logic [15:0] burst_cnt;
    logic        timeout;

    fifo_rd_check #(
        .DATA_W (8),
        .CNT_W  (16),
        .TIMEOUT(8)
    ) dut (
        .clk_50M     (clk_50M),
        .rst_n       (rst_n),
        .almost_full (almost_full),
        .almost_empty(almost_empty),
        .empty       (empty),
        .rd_data     (rd_data),
        .rd_en       (rd_en),
        .err_flag    (err_flag),
        .err_cnt     (err_cnt),
        .word_cnt    (word_cnt),
        .burst_cnt   (burst_cnt),
        .timeout     (timeout)
    );

    always #10 clk_50M = ~clk_50M;

    typedef struct {
        logic [7:0]  first;
        int unsigned len;
        int unsigned skip_at;
        int          af_lvl;
        int unsigned err_delta;
        bit          do_reset;
    } vec_t;

    typedef struct {
        int unsigned words;
        int unsigned errs;
    } sb_t;

    logic [7:0]  fq[$];
    sb_t         sb[$];
    int          af_lvl = 14;
    bit          af_force = 0;
    bit          force_empty = 0;
    bit          chk_pending = 0;
    bit          m_locked = 0;
    logic [7:0]  m_exp = '0;
    int unsigned m_words = 0;
    int unsigned m_errs = 0;
    int unsigned tot_words = 0;
    int unsigned tot_errs = 0;
    int unsigned tot_bursts = 0;
    int unsigned n_chk = 0;
    int unsigned n_pass = 0;

    task automatic chk(input string name, input int actual, input int expected);
        n_chk++;
        if (actual == expected)
            n_pass++;
        else
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    endtask

    task automatic update_flags();
        empty        = force_empty || (fq.size() == 0);
        almost_empty = (fq.size() == 1);
        almost_full  = af_force || (fq.size() >= af_lvl);
    endtask

    task automatic load(input logic [7:0] first, input int unsigned len, input int unsigned skip_at);
        logic [7:0] w;
        w = first;
        for (int unsigned i = 0; i < len; i++) begin
            if (skip_at != 0 && i == skip_at)
                w = w + 8'd1;
            fq.push_back(w);
            w = w + 8'd1;
        end
    endtask

    task automatic model_word(input logic [7:0] w);
        m_words++;
        if (m_locked && w != m_exp)
            m_errs++;
        m_locked = 1;
        m_exp    = w + 8'd1;
        sb.push_back('{words: m_words, errs: m_errs});
    endtask

    // One clock: pop on a sampled read at negedge, present data after the next edge, check a cycle later.
    task automatic step();
        logic       pop_now;
        logic [7:0] w;
        sb_t        e;
        w = '0;
        @(negedge clk_50M);
        chk("rd_en_while_empty", int'(rd_en & empty), 0);
        pop_now = rd_en && (fq.size() > 0);
        if (pop_now) begin
            w = fq.pop_front();
            model_word(w);
        end
        @(posedge clk_50M);
        #1;
        if (chk_pending) begin
            e = sb.pop_front();
            chk("sb_word_cnt", int'(word_cnt), int'(e.words));
            chk("sb_err_cnt", int'(err_cnt), int'(e.errs));
            chk("sb_err_flag", int'(err_flag), int'(e.errs > 0));
        end
        chk_pending = pop_now;
        if (pop_now)
            rd_data = w;
        update_flags();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        sb.delete();
        chk_pending = 0;
        m_locked = 0;
        m_exp = '0;
        m_words = 0;
        m_errs = 0;
        tot_words = 0;
        tot_errs = 0;
        tot_bursts = 0;
        update_flags();
        repeat (2) @(posedge clk_50M);
        #1;
        chk("rst_rd_en", int'(rd_en), 0);
        chk("rst_err_flag", int'(err_flag), 0);
        chk("rst_err_cnt", int'(err_cnt), 0);
        chk("rst_word_cnt", int'(word_cnt), 0);
        chk("rst_burst_cnt", int'(burst_cnt), 0);
        chk("rst_timeout", int'(timeout), 0);
        rst_n = 1'b1;
    endtask

    task automatic run_burst(input int unsigned budget);
        int unsigned n;
        n = 0;
        while (fq.size() > 0 && n < budget) begin
            step();
            n++;
        end
        chk("burst_drain_budget", fq.size(), 0);
        repeat (3) step();
    endtask

    task automatic chk_totals(input string tag);
        chk({tag, "_word_cnt"}, int'(word_cnt), int'(tot_words));
        chk({tag, "_err_cnt"}, int'(err_cnt), int'(tot_errs));
        chk({tag, "_err_flag"}, int'(err_flag), int'(tot_errs > 0));
        chk({tag, "_burst_cnt"}, int'(burst_cnt), int'(tot_bursts));
    endtask

    initial begin
        #2ms;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        vec_t vecs[5];
        vecs[0] = '{first: 8'h00, len: 16, skip_at: 0, af_lvl: 14, err_delta: 0, do_reset: 1};
        vecs[1] = '{first: 8'hFD, len: 5,  skip_at: 0, af_lvl: 5,  err_delta: 0, do_reset: 1};
        vecs[2] = '{first: 8'h10, len: 4,  skip_at: 2, af_lvl: 4,  err_delta: 1, do_reset: 1};
        vecs[3] = '{first: 8'h15, len: 6,  skip_at: 0, af_lvl: 6,  err_delta: 0, do_reset: 0};
        vecs[4] = '{first: 8'h30, len: 3,  skip_at: 0, af_lvl: 3,  err_delta: 1, do_reset: 0};

        update_flags();
        for (int i = 0; i < 5; i++) begin
            af_lvl = vecs[i].af_lvl;
            load(vecs[i].first, vecs[i].len, vecs[i].skip_at);
            if (vecs[i].do_reset) begin
                do_reset();
                step();
                chk("rd_en_after_release", int'(rd_en), 1);
            end else begin
                update_flags();
            end
            run_burst(vecs[i].len + 8);
            tot_words  += vecs[i].len;
            tot_errs   += vecs[i].err_delta;
            tot_bursts += 1;
            chk_totals($sformatf("vec%0d", i));
            chk($sformatf("vec%0d_timeout", i), int'(timeout), 0);
        end

        // Empty forced high mid-burst ends the burst; remaining words drain in a second burst.
        do_reset();
        af_lvl = 8;
        load(8'h40, 8, 0);
        update_flags();
        repeat (4) step();
        force_empty = 1;
        update_flags();
        step();
        chk("forced_empty_rd_en", int'(rd_en), 0);
        force_empty = 0;
        af_lvl = 1;
        update_flags();
        run_burst(16);
        tot_words = 8;
        tot_bursts = 2;
        chk_totals("empty_toggle");

        // almost_full and empty together in IDLE: READ entered, read held off until empty drops.
        do_reset();
        af_lvl = 99;
        load(8'h80, 2, 0);
        af_force = 1;
        force_empty = 1;
        update_flags();
        step();
        chk("af_empty_rd_en_held", int'(rd_en), 0);
        af_force = 0;
        force_empty = 0;
        update_flags();
        #1;
        chk("af_empty_rd_en_release", int'(rd_en), 1);
        run_burst(8);
        tot_words = 2;
        tot_bursts = 1;
        chk_totals("af_empty");

        // Asynchronous reset in the middle of a burst, then reseed on different data.
        do_reset();
        af_lvl = 10;
        load(8'h60, 10, 0);
        update_flags();
        repeat (4) step();
        #4;
        rst_n = 1'b0;
        #1;
        chk("midrst_rd_en", int'(rd_en), 0);
        chk("midrst_word_cnt", int'(word_cnt), 0);
        chk("midrst_burst_cnt", int'(burst_cnt), 0);
        fq.delete();
        do_reset();
        af_lvl = 3;
        load(8'h55, 3, 0);
        update_flags();
        run_burst(8);
        tot_words = 3;
        tot_bursts = 1;
        chk_totals("midrst_reseed");

        // Idle watchdog.
        do_reset();
        af_lvl = 99;
        update_flags();
`ifdef FIFO_RD_TIMEOUT_EN
        repeat (7) step();
        chk("timeout_cycle7", int'(timeout), 0);
        step();
        chk("timeout_cycle8", int'(timeout), 1);
        af_lvl = 2;
        load(8'hA0, 2, 0);
        update_flags();
        run_burst(8);
        chk("timeout_sticky", int'(timeout), 1);
        chk("timeout_burst_cnt", int'(burst_cnt), 1);
`else
        repeat (12) step();
        chk("timeout_disabled", int'(timeout), 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
